// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and defaults for the sprite scheduler.
// Holds the FSM state encoding and the default coordinate width.
package sprite_pkg;

   localparam int CORDW_DEF = 16;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      LAUNCH,
      WAIT
   } state_t;

endpackage

// File: rtl/sprite_sched_if.sv
// sprite_sched_if: slot-table config bus and sprite-engine handshake.
// Host masters the config bus; the scheduler masters the engine bus.
interface sprite_cfg_if
   import sprite_pkg::*;
#(
   parameter int SLOTS = 8,
   parameter int CORDW = CORDW_DEF
);
   logic                       cfg_we;
   logic [$clog2(SLOTS)-1:0]   cfg_slot;
   logic signed [CORDW-1:0]    cfg_x;
   logic signed [CORDW-1:0]    cfg_y;
   logic                       cfg_en;

   modport master (
      output cfg_we, cfg_slot, cfg_x, cfg_y, cfg_en
   );
   modport slave (
      input  cfg_we, cfg_slot, cfg_x, cfg_y, cfg_en
   );
endinterface

interface sprite_eng_if
   import sprite_pkg::*;
#(
   parameter int SLOTS = 8,
   parameter int CORDW = CORDW_DEF
);
   logic                       eng_start;
   logic [$clog2(SLOTS)-1:0]   eng_slot;
   logic [CORDW-1:0]           eng_x;
   logic                       eng_done;

   modport master (
      output eng_start, eng_slot, eng_x,
      input  eng_done
   );
   modport slave (
      input  eng_start, eng_slot, eng_x,
      output eng_done
   );
endinterface

// File: rtl/sprite_slot_table.sv
// sprite_slot_table: per-slot enable/x/y storage.
// One synchronous write port, one combinational read port.
module sprite_slot_table
   import sprite_pkg::*;
#(
   parameter int SLOTS = 8,
   parameter int CORDW = CORDW_DEF
) (
   input  logic                       i_clk_25,
   input  logic                       i_rst_n,
   input  logic                       i_we,
   input  logic [$clog2(SLOTS)-1:0]   i_wslot,
   input  logic signed [CORDW-1:0]    i_wx,
   input  logic signed [CORDW-1:0]    i_wy,
   input  logic                       i_wen,
   input  logic [$clog2(SLOTS)-1:0]   i_rslot,
   output logic                       o_ren,
   output logic signed [CORDW-1:0]    o_rx,
   output logic signed [CORDW-1:0]    o_ry
);

   logic                    r_en [SLOTS];
   logic signed [CORDW-1:0] r_x  [SLOTS];
   logic signed [CORDW-1:0] r_y  [SLOTS];

   // table write; readers in the same cycle still see the old entry
   always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < SLOTS; i++) begin
            r_en[i] <= 1'b0;
            r_x[i]  <= '0;
            r_y[i]  <= '0;
         end
      end else if (i_we) begin
         r_en[i_wslot] <= i_wen;
         r_x[i_wslot]  <= i_wx;
         r_y[i_wslot]  <= i_wy;
      end
   end

   assign o_ren = r_en[i_rslot];
   assign o_rx  = r_x[i_rslot];
   assign o_ry  = r_y[i_rslot];

endmodule

// File: rtl/sprite_sched.sv
// sprite_sched: per-scanline sprite scheduler for one shared engine.
// Define SPRITE_SCHED_ROTATE_EN to rotate the start slot after overflow.
module sprite_sched
   import sprite_pkg::*;
#(
   parameter int SLOTS        = 8,
   parameter int MAX_PER_LINE = 4,
   parameter int SPR_H        = 32,
   parameter int CORDW        = CORDW_DEF
) (
   input  logic                                i_clk_25,
   input  logic                                i_rst_n,
   input  logic                                line,
   input  logic signed [CORDW-1:0]             sy,
   sprite_cfg_if.slave                         cfg,
   sprite_eng_if.master                        eng,
   output logic                                overflow,
   output logic [$clog2(MAX_PER_LINE+1)-1:0]   launched
);

   localparam int SW = $clog2(SLOTS);
   localparam int LW = $clog2(MAX_PER_LINE+1);

   state_t                  r_state, w_state_nx;
   logic [SW-1:0]           r_idx, w_idx_nx;
   logic [SW-1:0]           r_cnt, w_cnt_nx;
   logic signed [CORDW-1:0] r_sy, w_sy_nx;
   logic [LW-1:0]           r_launched, w_launched_nx;
   logic                    r_ovf, w_ovf_nx;
   logic                    w_launch;
   logic [SW-1:0]           w_line_start;

   logic                    r_eng_start;
   logic [SW-1:0]           r_eng_slot;
   logic [CORDW-1:0]        r_eng_x;
   logic signed [CORDW-1:0] r_cand_x;

   logic                    w_ren;
   logic signed [CORDW-1:0] w_rx, w_ry;
   logic signed [CORDW:0]   w_sy_e, w_y_e, w_y_bot;
   logic                    w_hit, w_last;

   function automatic logic [SW-1:0] f_inc(input logic [SW-1:0] v);
      return (v == SW'(SLOTS-1)) ? '0 : v + 1'b1;
   endfunction

   sprite_slot_table #(
      .SLOTS (SLOTS),
      .CORDW (CORDW)
   ) u_tab (
      .i_clk_25 (i_clk_25),
      .i_rst_n  (i_rst_n),
      .i_we     (cfg.cfg_we),
      .i_wslot  (cfg.cfg_slot),
      .i_wx     (cfg.cfg_x),
      .i_wy     (cfg.cfg_y),
      .i_wen    (cfg.cfg_en),
      .i_rslot  (r_idx),
      .o_ren    (w_ren),
      .o_rx     (w_rx),
      .o_ry     (w_ry)
   );

   // one extra bit so y+SPR_H-1 near the top of the range cannot wrap
   assign w_sy_e  = {r_sy[CORDW-1], r_sy};
   assign w_y_e   = {w_ry[CORDW-1], w_ry};
   assign w_y_bot = w_y_e + (CORDW+1)'(SPR_H-1);
   assign w_hit   = w_ren && (w_sy_e >= w_y_e) && (w_sy_e <= w_y_bot);
   assign w_last  = (r_cnt == SW'(SLOTS-1));

`ifdef SPRITE_SCHED_ROTATE_EN
   logic [SW-1:0] r_start;

   // a line that overflowed hands the next line a later start slot
   always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
      if (!i_rst_n)
         r_start <= '0;
      else if (line && r_ovf)
         r_start <= f_inc(r_start);
   end

   assign w_line_start = r_ovf ? f_inc(r_start) : r_start;
`else
   assign w_line_start = '0;
`endif

   // next-state and per-line bookkeeping; a line pulse always restarts
   always_comb begin
      w_state_nx    = r_state;
      w_idx_nx      = r_idx;
      w_cnt_nx      = r_cnt;
      w_sy_nx       = r_sy;
      w_launched_nx = r_launched;
      w_ovf_nx      = r_ovf;
      w_launch      = 1'b0;
      if (line) begin
         w_state_nx    = SCAN;
         w_sy_nx       = sy;
         w_launched_nx = '0;
         w_ovf_nx      = 1'b0;
         w_idx_nx      = w_line_start;
         w_cnt_nx      = '0;
      end else begin
         unique case (r_state)
            IDLE: ;
            SCAN: begin
               if (w_hit && r_launched < LW'(MAX_PER_LINE)) begin
                  w_state_nx = LAUNCH;
               end else begin
                  if (w_hit)
                     w_ovf_nx = 1'b1;
                  if (w_last) begin
                     w_state_nx = IDLE;
                  end else begin
                     w_idx_nx = f_inc(r_idx);
                     w_cnt_nx = r_cnt + 1'b1;
                  end
               end
            end
            LAUNCH: begin
               w_launch      = 1'b1;
               w_launched_nx = r_launched + 1'b1;
               w_state_nx    = WAIT;
            end
            WAIT: begin
               if (eng.eng_done) begin
                  if (w_last) begin
                     w_state_nx = IDLE;
                  end else begin
                     w_state_nx = SCAN;
                     w_idx_nx   = f_inc(r_idx);
                     w_cnt_nx   = r_cnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // state and scan registers
   always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_cnt      <= '0;
         r_sy       <= '0;
         r_launched <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_idx      <= w_idx_nx;
         r_cnt      <= w_cnt_nx;
         r_sy       <= w_sy_nx;
         r_launched <= w_launched_nx;
         r_ovf      <= w_ovf_nx;
      end
   end

   // engine job: x staged at scan time so later table writes cannot leak in
   always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_eng_start <= 1'b0;
         r_eng_slot  <= '0;
         r_eng_x     <= '0;
         r_cand_x    <= '0;
      end else begin
         r_eng_start <= w_launch;
         if (r_state == SCAN)
            r_cand_x <= w_rx;
         if (w_launch) begin
            r_eng_slot <= r_idx;
            r_eng_x    <= r_cand_x;
         end
      end
   end

   assign eng.eng_start = r_eng_start;
   assign eng.eng_slot  = r_eng_slot;
   assign eng.eng_x     = r_eng_x;
   assign overflow      = r_ovf;
   assign launched      = r_launched;

endmodule

// File: tb/tb_sprite_sched.sv
// tb_sprite_sched: directed checks of the sprite scheduler.
// Build with SPRITE_SCHED_ROTATE_EN to exercise start-slot rotation.
module tb_sprite_sched;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              line = 1'b0;
   logic signed [15:0] sy = '0;
   logic              overflow;
   logic [2:0]        launched;

   int checks = 0;
   int errors = 0;
   int got_n;
   int got_lat;
   int got_slot [16];
   int got_x [16];

   sprite_cfg_if #(.SLOTS(8), .CORDW(16)) cfg ();
   sprite_eng_if #(.SLOTS(8), .CORDW(16)) eng ();

   sprite_sched #(
      .SLOTS        (8),
      .MAX_PER_LINE (4),
      .SPR_H        (32),
      .CORDW        (16)
   ) dut (
      .i_clk_25 (clk),
      .i_rst_n  (rst_n),
      .line     (line),
      .sy       (sy),
      .cfg      (cfg),
      .eng      (eng),
      .overflow (overflow),
      .launched (launched)
   );

   always #20 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      line = 1'b0;
      cfg.cfg_we = 1'b0;
      eng.eng_done = 1'b0;
      tick;
      tick;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic cfg_write(input int s, input int x, input int y,
                            input bit en);
      cfg.cfg_we = 1'b1;
      cfg.cfg_slot = 3'(s);
      cfg.cfg_x = 16'(x);
      cfg.cfg_y = 16'(y);
      cfg.cfg_en = en;
      tick;
      cfg.cfg_we = 1'b0;
   endtask

   task automatic pulse_line(input int v);
      line = 1'b1;
      sy = 16'(v);
      tick;
      line = 1'b0;
   endtask

   task automatic wait_start(output int cyc, input int maxc);
      cyc = 0;
      while (eng.eng_start !== 1'b1 && cyc < maxc) begin
         tick;
         cyc++;
      end
   endtask

   task automatic serve;
      int c;
      got_n = 0;
      got_lat = -1;
      while (got_n < 16) begin
         wait_start(c, 20);
         if (eng.eng_start !== 1'b1)
            break;
         if (got_n == 0)
            got_lat = c;
         got_slot[got_n] = int'(eng.eng_slot);
         got_x[got_n] = int'(eng.eng_x);
         got_n++;
         tick;
         tick;
         eng.eng_done = 1'b1;
         tick;
         eng.eng_done = 1'b0;
      end
   endtask

   task automatic test_reset;
      do_reset;
      checks++;
      if (eng.eng_start !== 1'b0) begin
         errors++;
         $display("FAIL rst_start: got %b exp 0", eng.eng_start);
      end
      checks++;
      if (eng.eng_slot !== 3'd0) begin
         errors++;
         $display("FAIL rst_slot: got %0d exp 0", eng.eng_slot);
      end
      checks++;
      if (eng.eng_x !== 16'd0) begin
         errors++;
         $display("FAIL rst_x: got %0d exp 0", eng.eng_x);
      end
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL rst_ovf: got %b exp 0", overflow);
      end
      checks++;
      if (launched !== 3'd0) begin
         errors++;
         $display("FAIL rst_launched: got %0d exp 0", launched);
      end
      // reset table: every slot disabled, even one whose y=0 matches sy=0
      pulse_line(0);
      serve;
      checks++;
      if (got_n !== 0) begin
         errors++;
         $display("FAIL rst_table: got %0d launches exp 0", got_n);
      end
   endtask

   task automatic test_single;
      int c;
      do_reset;
      cfg_write(2, 40, 100, 1'b1);
      // stray done in IDLE must be ignored
      eng.eng_done = 1'b1;
      tick;
      eng.eng_done = 1'b0;
      pulse_line(110);
      wait_start(c, 12);
      checks++;
      if (c !== 4 || eng.eng_start !== 1'b1) begin
         errors++;
         $display("FAIL single_lat: got %0d exp 4", c);
      end
      checks++;
      if (eng.eng_slot !== 3'd2) begin
         errors++;
         $display("FAIL single_slot: got %0d exp 2", eng.eng_slot);
      end
      checks++;
      if (eng.eng_x !== 16'd40) begin
         errors++;
         $display("FAIL single_x: got %0d exp 40", eng.eng_x);
      end
      tick;
      checks++;
      if (eng.eng_start !== 1'b0) begin
         errors++;
         $display("FAIL single_pulse: got %b exp 0", eng.eng_start);
      end
      eng.eng_done = 1'b1;
      tick;
      eng.eng_done = 1'b0;
      wait_start(c, 15);
      checks++;
      if (eng.eng_start !== 1'b0) begin
         errors++;
         $display("FAIL single_extra: got start exp none");
      end
      checks++;
      if (launched !== 3'd1 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL single_cnt: got %0d/%b exp 1/0",
                  launched, overflow);
      end
   endtask

   task automatic test_overflow;
      do_reset;
      for (int i = 0; i < 6; i++)
         cfg_write(i, 10 * i, 0, 1'b1);
      pulse_line(5);
      serve;
      checks++;
      if (got_n !== 4) begin
         errors++;
         $display("FAIL ovf_n: got %0d exp 4", got_n);
      end
      checks++;
      if (got_lat !== 2) begin
         errors++;
         $display("FAIL ovf_lat: got %0d exp 2", got_lat);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (got_slot[i] !== i || got_x[i] !== 10 * i) begin
            errors++;
            $display("FAIL ovf_seq%0d: got %0d/%0d exp %0d/%0d",
                     i, got_slot[i], got_x[i], i, 10 * i);
         end
      end
      checks++;
      if (overflow !== 1'b1 || launched !== 3'd4) begin
         errors++;
         $display("FAIL ovf_flags: got %b/%0d exp 1/4", overflow, launched);
      end
      pulse_line(5);
      checks++;
      if (overflow !== 1'b0 || launched !== 3'd0) begin
         errors++;
         $display("FAIL ovf_clear: got %b/%0d exp 0/0", overflow, launched);
      end
      serve;
      checks++;
      if (got_n !== 4) begin
         errors++;
         $display("FAIL line2_n: got %0d exp 4", got_n);
      end
      for (int i = 0; i < 4; i++) begin
`ifdef SPRITE_SCHED_ROTATE_EN
         checks++;
         if (got_slot[i] !== i + 1) begin
            errors++;
            $display("FAIL line2_slot%0d: got %0d exp %0d",
                     i, got_slot[i], i + 1);
         end
`else
         checks++;
         if (got_slot[i] !== i) begin
            errors++;
            $display("FAIL line2_slot%0d: got %0d exp %0d",
                     i, got_slot[i], i);
         end
`endif
      end
   endtask

   task automatic test_window;
      int vy  [7] = '{100, 100, 100, 100, 32760, -10, -10};
      int vsy [7] = '{131, 132, 99, 100, 32767, 21, 22};
      int vn  [7] = '{1, 0, 0, 1, 1, 1, 0};
      do_reset;
      for (int i = 0; i < 7; i++) begin
         cfg_write(0, 7, vy[i], 1'b1);
         pulse_line(vsy[i]);
         serve;
         checks++;
         if (got_n !== vn[i]) begin
            errors++;
            $display("FAIL window%0d y=%0d sy=%0d: got %0d exp %0d",
                     i, vy[i], vsy[i], got_n, vn[i]);
         end
      end
   endtask

   task automatic test_abort;
      int c;
      do_reset;
      cfg_write(1, 55, 0, 1'b1);
      pulse_line(3);
      wait_start(c, 10);
      checks++;
      if (c !== 3 || eng.eng_slot !== 3'd1) begin
         errors++;
         $display("FAIL abort_first: got %0d/%0d exp 3/1", c, eng.eng_slot);
      end
      tick;
      tick;
      pulse_line(4);
      checks++;
      if (launched !== 3'd0) begin
         errors++;
         $display("FAIL abort_clear: got %0d exp 0", launched);
      end
      // done while scanning belongs to no job and is dropped
      eng.eng_done = 1'b1;
      tick;
      eng.eng_done = 1'b0;
      wait_start(c, 10);
      checks++;
      if (c !== 2 || eng.eng_start !== 1'b1 || eng.eng_slot !== 3'd1) begin
         errors++;
         $display("FAIL abort_reissue: got %0d/%0d exp 2/1",
                  c, eng.eng_slot);
      end
      checks++;
      if (launched !== 3'd1) begin
         errors++;
         $display("FAIL abort_cnt: got %0d exp 1", launched);
      end
      tick;
      eng.eng_done = 1'b1;
      tick;
      eng.eng_done = 1'b0;
   endtask

   task automatic test_cfg_in_wait;
      int c;
      do_reset;
      cfg_write(1, 100, 0, 1'b1);
      pulse_line(0);
      wait_start(c, 10);
      tick;
      cfg_write(1, 200, 0, 1'b1);
      tick;
      checks++;
      if (eng.eng_x !== 16'd100 || eng.eng_slot !== 3'd1) begin
         errors++;
         $display("FAIL wait_hold: got %0d/%0d exp 100/1",
                  eng.eng_x, eng.eng_slot);
      end
      eng.eng_done = 1'b1;
      tick;
      eng.eng_done = 1'b0;
      wait_start(c, 15);
      pulse_line(0);
      serve;
      checks++;
      if (got_n !== 1 || got_x[0] !== 200) begin
         errors++;
         $display("FAIL wait_next: got %0d/%0d exp 1/200", got_n, got_x[0]);
      end
   endtask

   task automatic test_cfg_scan_race;
      int c;
      do_reset;
      cfg_write(0, 5, 0, 1'b1);
      pulse_line(0);
      // slot 0 is tested this cycle while being disabled
      cfg.cfg_we = 1'b1;
      cfg.cfg_slot = 3'd0;
      cfg.cfg_x = 16'd9;
      cfg.cfg_y = 16'd0;
      cfg.cfg_en = 1'b0;
      tick;
      cfg.cfg_we = 1'b0;
      wait_start(c, 10);
      checks++;
      if (c !== 1 || eng.eng_slot !== 3'd0 || eng.eng_x !== 16'd5) begin
         errors++;
         $display("FAIL race_old: got %0d/%0d/%0d exp 1/0/5",
                  c, eng.eng_slot, eng.eng_x);
      end
      tick;
      eng.eng_done = 1'b1;
      tick;
      eng.eng_done = 1'b0;
      wait_start(c, 15);
      pulse_line(0);
      serve;
      checks++;
      if (got_n !== 0) begin
         errors++;
         $display("FAIL race_new: got %0d exp 0", got_n);
      end
   endtask

   task automatic test_reset_mid;
      int c;
      do_reset;
      cfg_write(3, 1, 0, 1'b1);
      pulse_line(0);
      wait_start(c, 10);
      rst_n = 1'b0;
      #2;
      checks++;
      if (eng.eng_start !== 1'b0 || launched !== 3'd0 ||
          eng.eng_slot !== 3'd0) begin
         errors++;
         $display("FAIL midrst: got %b/%0d/%0d exp 0/0/0",
                  eng.eng_start, launched, eng.eng_slot);
      end
      tick;
      rst_n = 1'b1;
      eng.eng_done = 1'b1;
      tick;
      eng.eng_done = 1'b0;
      wait_start(c, 15);
      checks++;
      if (eng.eng_start !== 1'b0) begin
         errors++;
         $display("FAIL midrst_start: got 1 exp 0");
      end
   endtask

   initial begin
      cfg.cfg_we = 1'b0;
      cfg.cfg_slot = '0;
      cfg.cfg_x = '0;
      cfg.cfg_y = '0;
      cfg.cfg_en = 1'b0;
      eng.eng_done = 1'b0;
      test_reset;
      test_single;
      test_overflow;
      test_window;
      test_abort;
      test_cfg_in_wait;
      test_cfg_scan_race;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
